// File: rtl/uart_rx_frame_parser_pkg.sv
// Shared definitions for the UART frame parser: FSM states, error codes
// and the default sync bytes, kept here so a TX-side framer can reuse them.
package uart_rx_frame_parser_pkg;

  // Parser states, one per field of the frame.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD1 = 3'd1,
    S_LEN   = 3'd2,
    S_PAY   = 3'd3,
    S_CSUM  = 3'd4
  } state_e;

  // Abort reasons reported alongside the error pulse.
  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_CSUM = 2'd2,
    ERR_TMO  = 2'd3
  } err_e;

  // Default sync bytes that open every frame.
  localparam logic [7:0] HEAD0_DEF = 8'h55;
  localparam logic [7:0] HEAD1_DEF = 8'hAA;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle timer: counts clocks while enabled, restarts on clear,
// and emits a one-cycle expired pulse when TIMEOUT_CYC-1 is reached.
module uart_frame_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // A clear in the same cycle masks expiry, so a late byte always wins.
  assign o_expired = i_enable && !i_clear && (count_q == LAST);

  // Next count: restart on clear or expiry, otherwise step while enabled.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    count_d = count_q;
    if (i_clear || o_expired) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + ONE;
    end
  end

  // Counter register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (i_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame_parser.sv
// Frame parser behind the UART receiver: finds 55 AA LEN payload CSUM frames,
// forwards payload cut-through with first/last marks, and reports ok/abort.
module uart_rx_frame_parser
  import uart_rx_frame_parser_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] HEAD0       = HEAD0_DEF,
  parameter logic [DATA_WIDTH-1:0] HEAD1       = HEAD1_DEF,
  parameter int                    MAX_LEN     = 64,
  parameter int                    TIMEOUT_CYC = 50000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  o_first,
  output logic                  o_last,
  output logic [DATA_WIDTH-1:0] o_frame_len,
  output logic                  o_frame_ok,
  output logic                  o_frame_err,
  output logic [1:0]            o_err_code
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  err_e                  err_code_q, err_code_d;

  logic                  tmo_expired;
  logic                  len_bad;
  logic [DATA_WIDTH-1:0] cnt_inc;

  // The timer only runs inside a frame and restarts on every received byte.
  uart_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (i_rx_valid || (state_q == S_IDLE)),
    .i_enable  (state_q != S_IDLE),
    .o_expired (tmo_expired)
  );

  assign len_bad = (i_rx_data == '0) || (i_rx_data > MAX_LEN_B);
  assign cnt_inc = cnt_q + ONE;

  // Next-state, checksum, counters and next output values; a byte outranks a timeout.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    first_d    = 1'b0;
    last_d     = 1'b0;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = ERR_NONE;

    if (i_rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_rx_data == HEAD0) state_d = S_HEAD1;
        end
        S_HEAD1: begin
          if (i_rx_data == HEAD1)      state_d = S_LEN;
          else if (i_rx_data != HEAD0) state_d = S_IDLE;
        end
        S_LEN: begin
          if (len_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_IDLE;
          end else begin
            len_d   = i_rx_data;
            sum_d   = i_rx_data;
            cnt_d   = '0;
            state_d = S_PAY;
          end
        end
        S_PAY: begin
          data_d  = i_rx_data;
          valid_d = 1'b1;
          first_d = (cnt_q == '0);
          last_d  = (cnt_inc == len_q);
          sum_d   = sum_q + i_rx_data;
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) state_d = S_CSUM;
        end
        S_CSUM: begin
          if (i_rx_data == sum_q) begin
            ok_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (tmo_expired) begin
      // A stalled header is not yet a frame, so it is dropped silently.
      if (state_q != S_HEAD1) begin
        err_d      = 1'b1;
        err_code_d = ERR_TMO;
      end
      state_d = S_IDLE;
    end
  end

  // State, datapath and output registers; reset drops everything mid-frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sum_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      first_q    <= first_d;
      last_q     <= last_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_first     = first_q;
  assign o_last      = last_q;
  assign o_frame_len = len_q;
  assign o_frame_ok  = ok_q;
  assign o_frame_err = err_q;
  assign o_err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: each byte sent pushes the event
// it must cause, and a negedge monitor pops and compares value and cycle.
module tb_uart_rx_frame_parser;

  localparam int TMO     = 100;
  localparam int MAX_LEN = 64;

  typedef enum logic [1:0] {EV_PAY = 2'd0, EV_OK = 2'd1, EV_ERR = 2'd2} ev_kind_e;
  typedef struct packed {
    ev_kind_e   kind;
    logic [7:0] data;
    logic       first;
    logic       last;
    logic [1:0] code;
  } ev_t;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_rx_data = 8'h00;
  logic       i_rx_valid = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_first;
  logic       o_last;
  logic [7:0] o_frame_len;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  ev_t exp_q[$];
  int  due_q[$];

  uart_rx_frame_parser #(
    .DATA_WIDTH  (8),
    .HEAD0       (8'h55),
    .HEAD1       (8'hAA),
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_first     (o_first),
    .o_last      (o_last),
    .o_frame_len (o_frame_len),
    .o_frame_ok  (o_frame_ok),
    .o_frame_err (o_frame_err),
    .o_err_code  (o_err_code)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc++;

  // Monitor: every output event must match the oldest expectation, on its due cycle.
  always @(negedge i_clk) begin : monitor
    ev_t obs;
    ev_t exp_ev;
    int  due;
    if (!i_rst && (o_valid || o_frame_ok || o_frame_err)) begin
      obs = '0;
      if (o_valid) begin
        obs.kind  = EV_PAY;
        obs.data  = o_data;
        obs.first = o_first;
        obs.last  = o_last;
      end else if (o_frame_ok) begin
        obs.kind = EV_OK;
      end else begin
        obs.kind = EV_ERR;
        obs.code = o_err_code;
      end
      n_tests++;
      if (o_frame_ok && o_frame_err) begin
        n_fail++;
        $display("FAIL ok_err_exclusive: both high at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event: got kind=%0d data=%h first=%b last=%b code=%0d at cycle %0d, expected nothing",
                 obs.kind, obs.data, obs.first, obs.last, obs.code, cyc);
      end else begin
        exp_ev = exp_q.pop_front();
        due    = due_q.pop_front();
        if (obs !== exp_ev || cyc != due) begin
          n_fail++;
          $display("FAIL event: got kind=%0d data=%h first=%b last=%b code=%0d cycle=%0d, expected kind=%0d data=%h first=%b last=%b code=%0d cycle=%0d",
                   obs.kind, obs.data, obs.first, obs.last, obs.code, cyc,
                   exp_ev.kind, exp_ev.data, exp_ev.first, exp_ev.last, exp_ev.code, due);
        end
      end
    end
  end

  task automatic push_exp(input ev_kind_e kind, input logic [7:0] data, input logic first,
                          input logic last, input logic [1:0] code, input int due);
    ev_t e;
    e.kind  = kind;
    e.data  = data;
    e.first = first;
    e.last  = last;
    e.code  = code;
    exp_q.push_back(e);
    due_q.push_back(due);
  endtask

  // One byte strobe, starting and ending on a negedge.
  task automatic send_byte(input logic [7:0] b);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_pay(input logic [7:0] b, input logic first, input logic last);
    push_exp(EV_PAY, b, first, last, 2'd0, cyc + 1);
    send_byte(b);
  endtask

  task automatic send_ok(input logic [7:0] b);
    push_exp(EV_OK, 8'h00, 1'b0, 1'b0, 2'd0, cyc + 1);
    send_byte(b);
  endtask

  task automatic send_err(input logic [7:0] b, input logic [1:0] code);
    push_exp(EV_ERR, 8'h00, 1'b0, 1'b0, code, cyc + 1);
    send_byte(b);
  endtask

  // Complete frame with random payload; checksum is computed here.
  task automatic send_good_frame(input int len);
    logic [7:0] sum;
    logic [7:0] b;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'(len));
    sum = 8'(len);
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      sum = sum + b;
      send_pay(b, i == 0, i == len - 1);
    end
    send_ok(sum);
  endtask

  // Let pending events drain, then require an empty scoreboard.
  task automatic drain(input string name);
    repeat (4) @(negedge i_clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_events: %0d expected events never seen, expected 0", name, exp_q.size());
      exp_q.delete();
      due_q.delete();
    end
  endtask

  task automatic check_len(input string name, input logic [7:0] exp_len);
    n_tests++;
    if (o_frame_len !== exp_len) begin
      n_fail++;
      $display("FAIL %s_frame_len: got %h, expected %h", name, o_frame_len, exp_len);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({o_data, o_valid, o_first, o_last, o_frame_len, o_frame_ok, o_frame_err, o_err_code} !== '0) begin
      n_fail++;
      $display("FAIL %s_outputs_zero: data=%h valid=%b first=%b last=%b len=%h ok=%b err=%b code=%0d, expected all 0",
               name, o_data, o_valid, o_first, o_last, o_frame_len, o_frame_ok, o_frame_err, o_err_code);
    end
  endtask

  task automatic test_reset();
    #1;
    check_all_zero("reset_asserted");
    @(negedge i_clk);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    check_all_zero("reset_released");
  endtask

  task automatic test_good_frame();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_pay(8'h11, 1'b1, 1'b0);
    send_pay(8'h22, 1'b0, 1'b0);
    send_pay(8'h33, 1'b0, 1'b1);
    send_ok(8'h69);
    drain("good_frame");
    check_len("good_frame", 8'h03);
  endtask

  task automatic test_bad_csum();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_pay(8'h10, 1'b1, 1'b0);
    send_pay(8'h20, 1'b0, 1'b1);
    send_err(8'h00, 2'd2);
    drain("bad_csum");
  endtask

  task automatic test_bad_len();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_err(8'h00, 2'd1);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_err(8'h41, 2'd1);
    drain("bad_len");
  endtask

  task automatic test_resync();
    send_byte(8'h00);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_pay(8'h7F, 1'b1, 1'b1);
    send_ok(8'h80);
    drain("resync");
    check_len("resync", 8'h01);
  endtask

  task automatic test_timeout();
    // Stall after one payload byte: exactly one timeout abort, TMO clocks after it.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h04);
    send_pay(8'h01, 1'b1, 1'b0);
    push_exp(EV_ERR, 8'h00, 1'b0, 1'b0, 2'd3, cyc + TMO);
    repeat (TMO + 10) @(negedge i_clk);
    drain("timeout");
    // Stalled header returns silently.
    send_byte(8'h55);
    repeat (TMO + 10) @(negedge i_clk);
    drain("timeout_head1");
    // Next full frame parses normally: 02 + AB + CD = 7A.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h02);
    send_pay(8'hAB, 1'b1, 1'b0);
    send_pay(8'hCD, 1'b0, 1'b1);
    send_ok(8'h7A);
    drain("timeout_recover");
    // A byte arriving on the very cycle the timer expires wins.
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h02);
    repeat (TMO - 1) @(negedge i_clk);
    send_pay(8'h40, 1'b1, 1'b0);
    send_pay(8'h01, 1'b0, 1'b1);
    send_ok(8'h43);
    drain("timeout_race");
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h03);
    send_pay(8'h01, 1'b1, 1'b0);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    #1;
    check_all_zero("mid_frame_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_pay(8'h05, 1'b1, 1'b1);
    send_ok(8'h06);
    drain("after_reset");
    check_len("after_reset", 8'h01);
  endtask

  task automatic test_back_to_back();
    int len2;
    len2 = $urandom_range(1, MAX_LEN - 1);
    send_good_frame(MAX_LEN);
    send_good_frame(len2);
    send_good_frame(1);
    drain("back_to_back");
    check_len("back_to_back", 8'h01);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_resync();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
